// File: rtl/zoned_alarm_controller_if.sv
// Sensor/command inputs and actuator/status outputs of the zoned alarm controller.
// Valid-only command port, no backpressure; master drives inputs, slave is the controller.
interface zoned_alarm_controller_if #(
    parameter int ZONES = 4
);
    logic             on_off;
    logic [ZONES-1:0] zone_trip;
    logic [4:0]       cmd;
    logic             cmd_valid;
    logic [3:0]       leds;
    logic             siren;
    logic             send;
    logic             lock;
    logic [2:0]       state;
    logic [ZONES-1:0] zone_latched;
    logic [ZONES-1:0] bypass;

    modport master (
        output on_off, zone_trip, cmd, cmd_valid,
        input  leds, siren, send, lock, state, zone_latched, bypass
    );

    modport slave (
        input  on_off, zone_trip, cmd, cmd_valid,
        output leds, siren, send, lock, state, zone_latched, bypass
    );
endinterface

// File: rtl/zoned_alarm_controller.sv
// Multi-zone alarm FSM with entry delay, siren timeout, bypass and trip latching.
// Latency: 2 cycles input-to-output (input register + registered outputs); no backpressure.
module zoned_alarm_controller #(
    parameter int          ZONES         = 4,
    parameter logic [15:0] HUB_MASK      = 16'h0001,
    parameter int          ENTRY_DELAY   = 100,
    parameter int          SIREN_TIMEOUT = 1000
) (
    input  logic                     clock,
    input  logic                     reset,
    zoned_alarm_controller_if.slave  bus
);

    typedef enum logic [2:0] {
        S_DISARMED  = 3'd0,
        S_ARMED     = 3'd1,
        S_ENTRY     = 3'd2,
        S_ALARM     = 3'd3,
        S_EMERGENCY = 3'd4
    } state_t;

    localparam int CNT_MAX    = (ENTRY_DELAY > SIREN_TIMEOUT) ? ENTRY_DELAY : SIREN_TIMEOUT;
    localparam int CW         = $clog2(CNT_MAX + 1);
    localparam int ENTRY_LOAD = (ENTRY_DELAY > 0) ? ENTRY_DELAY - 1 : 0;
    localparam int SIREN_LOAD = SIREN_TIMEOUT - 1;

    localparam logic [4:0] CMD_DISARM = 5'h0A;
    localparam logic [4:0] CMD_ARM    = 5'h0B;
    localparam logic [4:0] CMD_PANIC  = 5'h0E;

    localparam logic [ZONES-1:0] HUB = HUB_MASK[ZONES-1:0];

    logic             on_off_r;
    logic             on_off_d;
    logic [ZONES-1:0] zone_trip_r;
    logic [4:0]       cmd_r;
    logic             cmd_valid_r;

    state_t           state_q;
    state_t           state_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             alarm_enter;

    logic [3:0]       leds_q;
    logic [3:0]       leds_d;
    logic             siren_q;
    logic             siren_d;
    logic             send_q;
    logic             send_d;
    logic             lock_q;
    logic             lock_d;
    logic [ZONES-1:0] latched_q;
    logic [ZONES-1:0] bypass_q;

    logic             arm_rise;
    logic             cmd_disarm;
    logic             cmd_arm;
    logic             cmd_panic;
    logic             cmd_bypass;
    logic [ZONES-1:0] tog_mask;
    logic [ZONES-1:0] eff;
    logic             hub_trip;
    logic             perim_trip;

    always_ff @(posedge clock) begin
        if (reset) begin
            on_off_r    <= 1'b0;
            on_off_d    <= 1'b0;
            zone_trip_r <= '0;
            cmd_r       <= '0;
            cmd_valid_r <= 1'b0;
        end else begin
            on_off_r    <= bus.on_off;
            on_off_d    <= on_off_r;
            zone_trip_r <= bus.zone_trip;
            cmd_r       <= bus.cmd;
            cmd_valid_r <= bus.cmd_valid;
        end
    end

    assign arm_rise   = on_off_r & ~on_off_d;
    assign cmd_disarm = cmd_valid_r && (cmd_r == CMD_DISARM);
    assign cmd_arm    = cmd_valid_r && (cmd_r == CMD_ARM);
    assign cmd_panic  = cmd_valid_r && (cmd_r == CMD_PANIC);
    assign cmd_bypass = cmd_valid_r && cmd_r[4];

    assign eff        = zone_trip_r & ~bypass_q;
    assign hub_trip   = |(eff & HUB);
    assign perim_trip = |(eff & ~HUB);

    // Zone indices beyond ZONES never match, so out-of-range toggles are dropped.
    always_comb begin
        tog_mask = '0;
        for (int i = 0; i < ZONES; i++) begin
            tog_mask[i] = (cmd_r[3:0] == 4'(i));
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = (cnt_q == '0) ? '0 : cnt_q - CW'(1);
        alarm_enter = 1'b0;
        case (state_q)
            S_DISARMED: begin
                if (cmd_arm || arm_rise) state_d = S_ARMED;
            end
            S_ARMED: begin
                if (cmd_disarm) begin
                    state_d = S_DISARMED;
                end else if (cmd_panic || hub_trip) begin
                    state_d = S_EMERGENCY;
                end else if (perim_trip) begin
                    if (ENTRY_DELAY == 0) begin
                        state_d     = S_ALARM;
                        cnt_d       = CW'(SIREN_LOAD);
                        alarm_enter = 1'b1;
                    end else begin
                        state_d = S_ENTRY;
                        cnt_d   = CW'(ENTRY_LOAD);
                    end
                end
            end
            S_ENTRY: begin
                if (cmd_disarm) begin
                    state_d = S_DISARMED;
                end else if (cmd_panic || hub_trip) begin
                    state_d = S_EMERGENCY;
                end else if (cnt_q == '0) begin
                    state_d     = S_ALARM;
                    cnt_d       = CW'(SIREN_LOAD);
                    alarm_enter = 1'b1;
                end
            end
            S_ALARM: begin
                if (cmd_disarm)                   state_d = S_DISARMED;
                else if (cmd_panic || hub_trip)   state_d = S_EMERGENCY;
                else if (cmd_arm)                 state_d = S_ARMED;
            end
            S_EMERGENCY: begin
                if (cmd_disarm)    state_d = S_DISARMED;
                else if (cmd_arm)  state_d = S_ARMED;
            end
            default: state_d = S_DISARMED;
        endcase
    end

    // Outputs are decoded from the next state so they register on the same edge as state.
    always_comb begin
        leds_d  = 4'b0001;
        siren_d = 1'b0;
        send_d  = 1'b0;
        lock_d  = 1'b0;
        case (state_d)
            S_ARMED:  leds_d = 4'b0010;
            S_ENTRY:  leds_d = 4'b0011;
            S_ALARM: begin
                leds_d  = 4'b0100;
                send_d  = 1'b1;
                siren_d = alarm_enter || (cnt_q != '0);
            end
            S_EMERGENCY: begin
                leds_d  = 4'b1000;
                siren_d = 1'b1;
                send_d  = 1'b1;
                lock_d  = 1'b1;
            end
            default: leds_d = 4'b0001;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_DISARMED;
            cnt_q     <= '0;
            leds_q    <= 4'b0001;
            siren_q   <= 1'b0;
            send_q    <= 1'b0;
            lock_q    <= 1'b0;
            latched_q <= '0;
            bypass_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            leds_q  <= leds_d;
            siren_q <= siren_d;
            send_q  <= send_d;
            lock_q  <= lock_d;
            if (state_q == S_DISARMED) begin
                if (state_d == S_ARMED) latched_q <= '0;
                if (cmd_bypass)         bypass_q  <= bypass_q ^ tog_mask;
            end else begin
                latched_q <= latched_q | eff;
            end
        end
    end

    assign bus.state        = state_q;
    assign bus.leds         = leds_q;
    assign bus.siren        = siren_q;
    assign bus.send         = send_q;
    assign bus.lock         = lock_q;
    assign bus.zone_latched = latched_q;
    assign bus.bypass       = bypass_q;

endmodule
